// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port (read latency 2) among NUM_REQ requesters.
// Optional grant locking for atomic read-modify-write is enabled by defining BRAM_ARB_LOCK_EN.
module bram_port_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 10,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   input  logic [NUM_REQ-1:0]            req_lock,
   output logic                          bram_en,
   output logic                          bram_we,
   output logic [ADDR_WIDTH-1:0]         bram_addr,
   output logic [DATA_WIDTH-1:0]         bram_din,
   input  logic [DATA_WIDTH-1:0]         bram_dout,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [ID_WIDTH-1:0]           rsp_id,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          busy
);

   logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0]    elig_s;
   logic                  grant_found_s;
   logic [ID_WIDTH-1:0]   grant_idx_s;
   logic                  bram_en_q, bram_en_d;
   logic                  bram_we_q, bram_we_d;
   logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
   logic [DATA_WIDTH-1:0] bram_din_q, bram_din_d;
   logic [ID_WIDTH-1:0]   issue_id_q, issue_id_d;
   logic [1:0]            pipe_vld_q, pipe_vld_d;
   logic [ID_WIDTH-1:0]   pipe_id0_q, pipe_id0_d;
   logic [ID_WIDTH-1:0]   pipe_id1_q, pipe_id1_d;
`ifdef BRAM_ARB_LOCK_EN
   logic                  lock_q, lock_d;
   logic [ID_WIDTH-1:0]   lock_owner_q, lock_owner_d;
`else
   logic                  lock_unused_s;
   assign lock_unused_s = ^req_lock;
`endif

   function automatic logic [ID_WIDTH-1:0] next_idx(input logic [ID_WIDTH-1:0] idx);
      if (idx == ID_WIDTH'(NUM_REQ - 1)) begin
         return '0;
      end else begin
         return idx + ID_WIDTH'(1);
      end
   endfunction

   always_comb begin
      elig_s = req_valid;
`ifdef BRAM_ARB_LOCK_EN
      if (lock_q) begin
         elig_s = '0;
         elig_s[lock_owner_q] = req_valid[lock_owner_q];
      end else begin
         elig_s = req_valid;
      end
`endif
   end

   // First eligible requester at or after ptr, wrapping past NUM_REQ-1.
   always_comb begin
      int idx_v;
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      idx_v         = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_v         = (int'(ptr_q) + k) % NUM_REQ;
         grant_idx_s   = (!grant_found_s && elig_s[idx_v]) ? ID_WIDTH'(idx_v) : grant_idx_s;
         grant_found_s = grant_found_s | elig_s[idx_v];
      end
   end

   always_comb begin
      req_ready = '0;
      if (grant_found_s) begin
         req_ready[grant_idx_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   always_comb begin
      ptr_d       = ptr_q;
      bram_en_d   = 1'b0;
      bram_we_d   = 1'b0;
      bram_addr_d = bram_addr_q;
      bram_din_d  = bram_din_q;
      issue_id_d  = issue_id_q;
`ifdef BRAM_ARB_LOCK_EN
      lock_d       = lock_q;
      lock_owner_d = lock_owner_q;
`endif
      if (grant_found_s) begin
         bram_en_d   = 1'b1;
         bram_we_d   = req_we[grant_idx_s];
         bram_addr_d = req_addr[int'(grant_idx_s) * ADDR_WIDTH +: ADDR_WIDTH];
         bram_din_d  = req_wdata[int'(grant_idx_s) * DATA_WIDTH +: DATA_WIDTH];
         issue_id_d  = grant_idx_s;
`ifdef BRAM_ARB_LOCK_EN
         // A locking accept freezes ptr; the releasing accept moves it past the owner.
         if (req_lock[grant_idx_s]) begin
            lock_d       = 1'b1;
            lock_owner_d = grant_idx_s;
         end else begin
            lock_d = 1'b0;
            ptr_d  = next_idx(grant_idx_s);
         end
`else
         ptr_d = next_idx(grant_idx_s);
`endif
      end else begin
         ptr_d = ptr_q;
      end
      // Read tags follow the issued command through the two BRAM latency stages.
      pipe_vld_d = {pipe_vld_q[0], bram_en_q & ~bram_we_q};
      pipe_id0_d = issue_id_q;
      pipe_id1_d = pipe_id0_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         bram_en_q   <= 1'b0;
         bram_we_q   <= 1'b0;
         bram_addr_q <= '0;
         bram_din_q  <= '0;
         issue_id_q  <= '0;
         pipe_vld_q  <= 2'b00;
         pipe_id0_q  <= '0;
         pipe_id1_q  <= '0;
`ifdef BRAM_ARB_LOCK_EN
         lock_q       <= 1'b0;
         lock_owner_q <= '0;
`endif
      end else begin
         ptr_q       <= ptr_d;
         bram_en_q   <= bram_en_d;
         bram_we_q   <= bram_we_d;
         bram_addr_q <= bram_addr_d;
         bram_din_q  <= bram_din_d;
         issue_id_q  <= issue_id_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_id0_q  <= pipe_id0_d;
         pipe_id1_q  <= pipe_id1_d;
`ifdef BRAM_ARB_LOCK_EN
         lock_q       <= lock_d;
         lock_owner_q <= lock_owner_d;
`endif
      end
   end

   always_comb begin
      rsp_valid = '0;
      rsp_id    = '0;
      if (pipe_vld_q[1]) begin
         rsp_valid[pipe_id1_q] = 1'b1;
         rsp_id                = pipe_id1_q;
      end else begin
         rsp_valid = '0;
         rsp_id    = '0;
      end
   end

   assign bram_en   = bram_en_q;
   assign bram_we   = bram_we_q;
   assign bram_addr = bram_addr_q;
   assign bram_din  = bram_din_q;
   assign rsp_data  = bram_dout;
   assign busy      = bram_en_q | (|pipe_vld_q);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and a 2-cycle no_change BRAM model.
module tb_bram_port_arbiter;
   localparam int NR = 4;
   localparam int DW = 64;
   localparam int AW = 10;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req_valid, req_ready, req_we, req_lock, rsp_valid;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic              bram_en, bram_we, busy;
   logic [AW-1:0]     bram_addr;
   logic [DW-1:0]     bram_din, rsp_data;
   logic [DW-1:0]     bram_dout = '0;
   logic [IW-1:0]     rsp_id;

   int n_checks = 0;
   int n_fail   = 0;

   bram_port_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_lock(req_lock),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
      .bram_dout(bram_dout), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // BRAM model: read latency 2, write mode no_change.
   logic [DW-1:0] bram_mem [0:1023];
   logic [DW-1:0] bram_st1 = '0;
   always @(posedge clk) begin
      if (bram_en) begin
         if (bram_we) bram_mem[bram_addr] <= bram_din;
         else         bram_st1 <= bram_mem[bram_addr];
      end
      bram_dout <= bram_st1;
   end

   // Reference model state
   logic [DW-1:0] ref_mem [0:1023];
   int m_ptr, m_owner;
   bit m_lock;
   typedef struct { int due; int id; logic [DW-1:0] data; } rsp_t;
   rsp_t exp_q[$];

   function automatic int ref_grant(input logic [NR-1:0] v);
      for (int k = 0; k < NR; k++) begin
         int i;
         i = (m_ptr + k) % NR;
         if (v[i] && (!m_lock || i == m_owner)) return i;
      end
      return -1;
   endfunction

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      m_ptr = 0; m_lock = 1'b0; m_owner = 0;
      exp_q.delete();
   endtask

   task automatic set_req(input int i, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit lk);
      req_we[i] = we;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
      req_lock[i] = lk;
   endtask

   task automatic test_reset;
      do_reset;
      @(negedge clk);
      n_checks++;
      if ({bram_en, bram_we, bram_addr, bram_din, rsp_valid, rsp_id, busy} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: en=%b we=%b addr=%h din=%h rsp_valid=%b rsp_id=%0d busy=%b, expected all 0",
                  bram_en, bram_we, bram_addr, bram_din, rsp_valid, rsp_id, busy);
      end
      n_checks++;
      if (req_ready !== 4'b0000) begin
         n_fail++; $display("FAIL reset_ready_idle: got %b expected 0000", req_ready);
      end
      req_valid = 4'b0110;
      #1;
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_fail++; $display("FAIL reset_ptr0: got %b expected 0010", req_ready);
      end
      req_valid = 4'b0000;
   endtask

   task automatic test_single_read;
      do_reset;
      set_req(2, 1'b0, 10'h005, '0, 1'b0);
      req_valid = 4'b0100;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0100) begin
         n_fail++; $display("FAIL single_grant: got %b expected 0100", req_ready);
      end
      next_cycle;
      req_valid = 4'b0000;
      @(negedge clk);
      n_checks++;
      if ({bram_en, bram_we, bram_addr} !== {1'b1, 1'b0, 10'h005}) begin
         n_fail++; $display("FAIL single_issue: en=%b we=%b addr=%h expected 1 0 005", bram_en, bram_we, bram_addr);
      end
      next_cycle;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 4'b0000) begin
         n_fail++; $display("FAIL single_early_rsp: got %b expected 0000", rsp_valid);
      end
      next_cycle;
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_data} !== {4'b0100, 2'd2, 64'hA5}) begin
         n_fail++; $display("FAIL single_rsp: valid=%b id=%0d data=%h expected 0100 2 a5", rsp_valid, rsp_id, rsp_data);
      end
      next_cycle;
   endtask

   task automatic test_contention;
      do_reset;
      for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(16 + i), '0, 1'b0);
      req_valid = 4'b1111;
      for (int c = 0; c < 11; c++) begin
         logic [3:0] e;
         int id;
         if (c == 8) req_valid = 4'b0000;
         @(negedge clk);
         if (c < 8) begin
            e = 4'b0001 << (c % 4);
            n_checks++;
            if (req_ready !== e) begin
               n_fail++; $display("FAIL contention_grant[%0d]: got %b expected %b", c, req_ready, e);
            end
         end
         if (c >= 3) begin
            id = (c - 3) % 4;
            e  = 4'b0001 << id;
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_data} !== {e, IW'(id), ref_mem[16 + id]}) begin
               n_fail++; $display("FAIL contention_rsp[%0d]: valid=%b id=%0d data=%h expected %b %0d %h",
                                  c, rsp_valid, rsp_id, rsp_data, e, id, ref_mem[16 + id]);
            end
         end else begin
            n_checks++;
            if (rsp_valid !== 4'b0000) begin
               n_fail++; $display("FAIL contention_early_rsp[%0d]: got %b expected 0000", c, rsp_valid);
            end
         end
         next_cycle;
      end
   endtask

   task automatic test_write_read;
      do_reset;
      set_req(1, 1'b1, 10'd7, 64'h1234, 1'b0);
      req_valid = 4'b0010;
      ref_mem[7] = 64'h1234;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_fail++; $display("FAIL wr_grant: got %b expected 0010", req_ready);
      end
      next_cycle;
      set_req(3, 1'b0, 10'd7, '0, 1'b0);
      req_valid = 4'b1000;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b1000) begin
         n_fail++; $display("FAIL rd_grant: got %b expected 1000", req_ready);
      end
      n_checks++;
      if ({bram_en, bram_we, bram_addr, bram_din} !== {1'b1, 1'b1, 10'd7, 64'h1234}) begin
         n_fail++; $display("FAIL wr_issue: en=%b we=%b addr=%h din=%h expected 1 1 007 1234", bram_en, bram_we, bram_addr, bram_din);
      end
      next_cycle;
      req_valid = 4'b0000;
      for (int c = 2; c < 5; c++) begin
         @(negedge clk);
         n_checks++;
         if (c < 4 && rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL wr_no_rsp[%0d]: got %b expected 0000", c, rsp_valid);
         end else if (c == 4 && {rsp_valid, rsp_id, rsp_data} !== {4'b1000, 2'd3, 64'h1234}) begin
            n_fail++; $display("FAIL raw_rsp: valid=%b id=%0d data=%h expected 1000 3 1234", rsp_valid, rsp_id, rsp_data);
         end
         next_cycle;
      end
   endtask

   task automatic test_reset_midflight;
      do_reset;
      set_req(0, 1'b0, 10'd1, '0, 1'b0);
      req_valid = 4'b0001;
      next_cycle;
      set_req(1, 1'b0, 10'd2, '0, 1'b0);
      req_valid = 4'b0010;
      next_cycle;
      rst_n = 1'b0;
      req_valid = 4'b0000;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_checks++;
         if ({bram_en, bram_we, bram_addr, bram_din, rsp_valid, rsp_id, busy} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs[%0d]: en=%b addr=%h rsp_valid=%b busy=%b expected all 0",
                     c, bram_en, bram_addr, rsp_valid, busy);
         end
         next_cycle;
      end
      rst_n = 1'b1;
      m_ptr = 0; m_lock = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_checks++;
         if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_dropped[%0d]: rsp_valid=%b busy=%b expected 0000 0", c, rsp_valid, busy);
         end
         next_cycle;
      end
      set_req(3, 1'b0, 10'd4, '0, 1'b0);
      req_valid = 4'b1010;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_fail++; $display("FAIL midrst_first_grant: got %b expected 0010", req_ready);
      end
      next_cycle;
      req_valid = 4'b0000;
      repeat (4) next_cycle;
   endtask

   task automatic test_lock;
      do_reset;
      set_req(0, 1'b0, 10'd3, '0, 1'b1);
      set_req(1, 1'b0, 10'd9, '0, 1'b0);
      req_valid = 4'b0011;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_fail++; $display("FAIL lock_first: got %b expected 0001", req_ready);
      end
      next_cycle;
      req_valid = 4'b0010;
`ifdef BRAM_ARB_LOCK_EN
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0000) begin
         n_fail++; $display("FAIL lock_hold: got %b expected 0000", req_ready);
      end
      next_cycle;
      set_req(0, 1'b1, 10'd3, 64'hBEEF, 1'b0);
      ref_mem[3] = 64'hBEEF;
      req_valid = 4'b0011;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_fail++; $display("FAIL lock_owner_wr: got %b expected 0001", req_ready);
      end
      next_cycle;
      req_valid = 4'b0010;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_fail++; $display("FAIL lock_release: got %b expected 0010", req_ready);
      end
`else
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_fail++; $display("FAIL lock_ignored: got %b expected 0010", req_ready);
      end
`endif
      next_cycle;
      req_valid = 4'b0000;
      repeat (4) next_cycle;
   endtask

   task automatic test_random;
      logic [NR-1:0] pend;
      bit exp_en, exp_we;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_din;
      int g;
      do_reset;
      pend = '0;
      exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_din = '0;
      for (int cyc = 0; cyc < 408; cyc++) begin
         logic [NR-1:0] e_rdy, e_rsp;
         bit e_busy;
         for (int i = 0; i < NR; i++) begin
            if (!pend[i] && cyc < 400 && $urandom_range(0, 9) < 6) begin
               pend[i] = 1'b1;
               set_req(i, $urandom_range(0, 2) == 0, AW'(32 + $urandom_range(0, 31)),
                       {$urandom, $urandom}, $urandom_range(0, 3) == 0);
            end
         end
         req_valid = pend;
         @(negedge clk);
         g = ref_grant(req_valid);
         e_rdy = (g < 0) ? 4'b0000 : (4'b0001 << g);
         n_checks++;
         if (req_ready !== e_rdy) begin
            n_fail++; $display("FAIL rnd_grant[%0d]: got %b expected %b", cyc, req_ready, e_rdy);
         end
         n_checks++;
         if ((exp_en && {bram_en, bram_we, bram_addr, bram_din} !== {1'b1, exp_we, exp_addr, exp_din}) ||
             (!exp_en && {bram_en, bram_we} !== 2'b00)) begin
            n_fail++; $display("FAIL rnd_issue[%0d]: en=%b we=%b addr=%h din=%h expected %b %b %h %h",
                               cyc, bram_en, bram_we, bram_addr, bram_din, exp_en, exp_we, exp_addr, exp_din);
         end
         e_busy = exp_en;
         foreach (exp_q[k]) if (exp_q[k].due == cyc || exp_q[k].due == cyc + 1) e_busy = 1'b1;
         n_checks++;
         if (busy !== e_busy) begin
            n_fail++; $display("FAIL rnd_busy[%0d]: got %b expected %b", cyc, busy, e_busy);
         end
         n_checks++;
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e_rsp = 4'b0001 << exp_q[0].id;
            if ({rsp_valid, rsp_id, rsp_data} !== {e_rsp, IW'(exp_q[0].id), exp_q[0].data}) begin
               n_fail++; $display("FAIL rnd_rsp[%0d]: valid=%b id=%0d data=%h expected %b %0d %h",
                                  cyc, rsp_valid, rsp_id, rsp_data, e_rsp, exp_q[0].id, exp_q[0].data);
            end
            void'(exp_q.pop_front());
         end else if (rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL rnd_spurious_rsp[%0d]: got %b expected 0000", cyc, rsp_valid);
         end
         if (g >= 0) begin
            exp_en   = 1'b1;
            exp_we   = req_we[g];
            exp_addr = req_addr[g*AW +: AW];
            exp_din  = req_wdata[g*DW +: DW];
            if (exp_we) ref_mem[exp_addr] = exp_din;
            else        exp_q.push_back('{due: cyc + 3, id: g, data: ref_mem[exp_addr]});
`ifdef BRAM_ARB_LOCK_EN
            if (req_lock[g]) begin
               m_lock = 1'b1; m_owner = g;
            end else begin
               m_lock = 1'b0; m_ptr = (g + 1) % NR;
            end
`else
            m_ptr = (g + 1) % NR;
`endif
         end else begin
            exp_en = 1'b0;
            exp_we = 1'b0;
         end
         next_cycle;
         if (g >= 0) pend[g] = 1'b0;
      end
      req_valid = '0;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL rnd_drain: %0d responses outstanding, expected 0", exp_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         logic [DW-1:0] v;
         v = {$urandom, $urandom};
         bram_mem[i] = v;
         ref_mem[i]  = v;
      end
      bram_mem[5] = 64'hA5;
      ref_mem[5]  = 64'hA5;
      test_reset;
      test_single_read;
      test_contention;
      test_write_read;
      test_reset_midflight;
      test_lock;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Round-robin arbiter and sequencer that shares one port of the team's true-dual-port BRAM (common clock, read latency 2, write mode no_change) among NUM_REQ requesters, e.g. RX lookup, TX lookup and host table writes. It accepts at most one read or write per cycle, drives a registered BRAM command, tracks in-flight reads through the 2-cycle BRAM pipeline and returns read data to the originating requester with its index. Each BRAM port of a lookup table gets one instance.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_WIDTH, 64: BRAM word width.
- ADDR_WIDTH, 10: BRAM address width.
- ID_WIDTH, $clog2(NUM_REQ): requester index width.

- clk  in  1  single clock; the BRAM port is clocked from the same clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_ready  out  NUM_REQ  accept; at most one bit high per cycle.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed, same layout as req_addr.
- req_lock  in  NUM_REQ  hold grant after this transaction; only honoured with BRAM_ARB_LOCK_EN.
- bram_en  out  1  BRAM port enable.
- bram_we  out  1  BRAM port write enable.
- bram_addr  out  ADDR_WIDTH  BRAM port address.
- bram_din  out  DATA_WIDTH  BRAM port write data.
- bram_dout  in  DATA_WIDTH  BRAM port read data, valid 2 cycles after bram_en.
- rsp_valid  out  NUM_REQ  one-cycle read-data strobe to the originating requester.
- rsp_id  out  ID_WIDTH  index of the requester whose read returns this cycle.
- rsp_data  out  DATA_WIDTH  equals bram_dout; broadcast to all requesters.
- busy  out  1  a command is being issued or a read is in flight.

## Operation
- Accept rule: a transaction from requester i is accepted when req_valid[i] and req_ready[i] are both high. req_ready is combinational from req_valid and the arbiter state, and never depends on req_ready itself.
- Grant: round-robin pointer ptr. The grant goes to the lowest valid index ≥ ptr, wrapping around at NUM_REQ-1 to 0. After each accept, ptr = granted index + 1 mod NUM_REQ. Idle cycles leave ptr unchanged.
- Issue register: on accept, the next edge loads bram_en=1 and bram_we, bram_addr and bram_din from the winner. With no accept, bram_en=0 and bram_we=0; addr and din hold their last value.
- Read tracking: 2-deep shift pipe of {valid, id}, aligned with the BRAM latency. An entry is loaded only for reads (we=0). Writes produce no response.
- Response: when the pipe tail is valid, rsp_valid[id]=1, rsp_id=id and rsp_data=bram_dout, all combinational from the tail and the input.
- Requesters must sink responses; there is no backpressure on responses.
- Ordering is preserved at the port, so a read accepted after a write to the same address returns the new data.
- busy = bram_en OR any valid pipe entry.
- Reset mid-operation clears the issue register and the pipe. In-flight reads are dropped and never produce rsp_valid. ptr returns to 0.

## Timing
- Reset values: req_ready follows the combinational rule with ptr=0. bram_en=0, bram_we=0, bram_addr=0, bram_din=0, rsp_valid=0, rsp_id=0, busy=0.
- Read accepted in cycle T: bram_en=1 in T+1, rsp_valid in T+3. Read-to-response latency is 3 cycles.
- Write accepted in cycle T: bram_en=bram_we=1 in T+1, and the memory is updated at the end of T+1.
- Throughput: one accept per cycle sustained. Back-to-back reads give back-to-back responses.
- Simultaneous requests: exactly one is granted. The others keep req_valid high and their payload stable until accepted.

## Configuration
- BRAM_ARB_LOCK_EN defined: a lock flag and a lock owner register are added.
  - Accepting a transaction with req_lock[i]=1 sets lock to owner i.
  - While locked, only requester i can be granted, and ptr is frozen.
  - Accepting a transaction from the owner with req_lock=0 releases the lock; ptr then advances to owner+1.
  - This enables atomic read-modify-write.
  - Reset clears the lock.
- BRAM_ARB_LOCK_EN undefined: req_lock is present but ignored, and the arbiter is pure round-robin.

## Test plan
- Single read: after reset, requester 2 reads addr 0x005 holding 0xA5 → bram_en at T+1; rsp_valid=4'b0100, rsp_id=2, rsp_data=0xA5 at T+3.
- Contention: all four requesters hold reads continuously for 8 cycles → grants are 0,1,2,3,0,1,2,3 and 8 responses arrive in the same order, 3 cycles after each grant.
- Write then read: requester 1 writes 0x1234 to addr 7, then requester 3 reads addr 7 the next cycle → response to requester 3 with 0x1234; no response for the write.
- Reset mid-flight: issue two reads, then assert rst_n=0 at T+2 → no rsp_valid afterwards, all outputs at reset values, and the first post-reset grant goes to the lowest valid index.
- Lock (BRAM_ARB_LOCK_EN): requester 0 reads addr 3 with lock=1 while requester 1 is valid → requester 1 is not granted until requester 0 writes addr 3 with lock=0; requester 1 is granted the next cycle.
